// File: rtl/prbs7_checker.sv
// rtl/prbs7_checker.sv - self-synchronising PRBS-7 (x^7+x+1) serial pattern checker
module prbs7_checker #(
  parameter int LOCK_CNT    = 16,
  parameter int LOSS_THRESH = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             din,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  typedef enum logic [1:0] {SYNC = 2'd0, LOCKING = 2'd1, LOCKED = 2'd2} state_t;

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_THRESH + 1);
  localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_CNT - 1);
  localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_THRESH - 1);

  state_t        state, state_next;
  logic [6:0]    h;
  logic [2:0]    fill;
  logic [MW-1:0] match;
  logic [LW-1:0] miss;

  logic          p;
  logic          miss_bit;
  logic [6:0]    h_din;
  logic          fill_done;
  logic          lock_done;
  logic          loss;

  // h[0] is the oldest bit; the generator's recurrence gives the next bit as h[0]^h[1]
  assign p         = h[0] ^ h[1];
  assign miss_bit  = din ^ p;
  assign h_din     = {din, h[6:1]};
  // Seventh fill shift (counter saturates at 7); an all-zero window is never trusted
  assign fill_done = (fill >= 3'd6) && (h_din != 7'd0);
  assign lock_done = !miss_bit && (match == LOCK_LAST);
  assign loss      = miss_bit && (miss == LOSS_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= SYNC;
    else       state <= state_next;
  end

  // Next-state logic: only enabled samples can move the FSM
  always_comb begin
    state_next = state;
    if (enable) begin
      case (state)
        SYNC:    if (fill_done) state_next = LOCKING;
        LOCKING: begin
          if (miss_bit)       state_next = SYNC;
          else if (lock_done) state_next = LOCKED;
        end
        LOCKED:  if (loss) state_next = SYNC;
        default: state_next = SYNC;
      endcase
    end
  end

  // Output logic: lock status comes straight from the state register
  always_comb begin
    locked = (state == LOCKED);
  end

  // Datapath: history, fill/match/miss counters, error pulse and statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      h         <= '0;
      fill      <= '0;
      match     <= '0;
      miss      <= '0;
      err       <= 1'b0;
      err_count <= '0;
      bit_count <= '0;
    end else begin
      err <= 1'b0;
      if (enable) begin
        case (state)
          SYNC: begin
            h <= h_din;
            if (fill != 3'd7) fill <= fill + 3'd1;
          end
          LOCKING: begin
            h <= h_din;
            if (miss_bit) begin
              fill  <= '0;
              match <= '0;
            end else if (lock_done) begin
              match <= '0;
            end else begin
              match <= match + 1'b1;
            end
          end
          LOCKED: begin
            // Flywheel: feed back the prediction so a corrupted bit never enters h
            h <= {p, h[6:1]};
            if (bit_count != {CNT_W{1'b1}}) bit_count <= bit_count + 1'b1;
            if (miss_bit) begin
              err <= 1'b1;
              if (err_count != {CNT_W{1'b1}}) err_count <= err_count + 1'b1;
              if (loss) begin
                miss  <= '0;
                fill  <= '0;
                match <= '0;
              end else begin
                miss <= miss + 1'b1;
              end
            end else begin
              miss <= '0;
            end
          end
          default: begin
            fill  <= '0;
            match <= '0;
            miss  <= '0;
          end
        endcase
      end
    end
  end

endmodule
